// File: rtl/bp_cfg_field_streamer.sv
// rtl/bp_cfg_field_streamer.sv - streams a packed config one field per transfer, closed by a negated-sum checksum word
module bp_cfg_field_streamer #(
    parameter int field_count_p = 40,
    parameter int field_width_p = 16,
    localparam int idx_width_lp = (field_count_p + 1 <= 2) ? 1 : $clog2(field_count_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic [field_count_p*field_width_p-1:0] cfg_i,
    output logic                                   busy_o,
    output logic                                   v_o,
    input  logic                                   ready_i,
    output logic [field_width_p-1:0]               data_o,
    output logic [idx_width_lp-1:0]                idx_o,
    output logic                                   last_o,
    output logic                                   done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_e;

    state_e                                 state_r;
    state_e                                 state_n;
    logic [field_count_p*field_width_p-1:0] snap_r;
    logic [idx_width_lp-1:0]                idx_r;
    logic [field_width_p-1:0]               csum_r;
    logic [field_width_p-1:0]               field_sel;
    logic                                   done_r;
    logic                                   xfer;
    logic                                   last_field;

    assign xfer       = v_o & ready_i;
    assign last_field = (idx_r == idx_width_lp'(field_count_p - 1));
    assign done_o     = done_r;

    // Compare-based mux keeps the index width independent of the field count.
    always_comb begin
        field_sel = '0;
        for (int k = 0; k < field_count_p; k++) begin
            if (idx_r == idx_width_lp'(k)) begin
                field_sel = snap_r[k*field_width_p +: field_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (start_i) state_n = SEND;
            SEND:    if (xfer && last_field) state_n = CSUM;
            CSUM:    if (xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        busy_o = 1'b0;
        v_o    = 1'b0;
        data_o = '0;
        idx_o  = '0;
        last_o = 1'b0;
        case (state_r)
            SEND: begin
                busy_o = 1'b1;
                v_o    = 1'b1;
                data_o = field_sel;
                idx_o  = idx_r;
            end
            CSUM: begin
                busy_o = 1'b1;
                v_o    = 1'b1;
                data_o = -csum_r;
                idx_o  = idx_width_lp'(field_count_p);
                last_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            snap_r <= '0;
            idx_r  <= '0;
            csum_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == CSUM) && xfer;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        snap_r <= cfg_i;
                        idx_r  <= '0;
                        csum_r <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        csum_r <= csum_r + field_sel;
                        if (!last_field) begin
                            idx_r <= idx_r + idx_width_lp'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_field_streamer.sv
// tb/tb_bp_cfg_field_streamer.sv - scoreboard bench for bp_cfg_field_streamer
module tb_bp_cfg_field_streamer;

    localparam int FC = 4;
    localparam int FW = 8;
    localparam int IW = $clog2(FC + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          ready_i;
    logic [FC*FW-1:0] cfg_i;
    logic          busy_o, v_o, last_o, done_o;
    logic [FW-1:0] data_o;
    logic [IW-1:0] idx_o;

    logic          start1, ready1;
    logic [FW-1:0] cfg1;
    logic          busy1, v1, last1, done1;
    logic [FW-1:0] data1;
    logic [0:0]    idx1;

    always #5 clk = ~clk;

    bp_cfg_field_streamer #(.field_count_p(FC), .field_width_p(FW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .cfg_i(cfg_i),
        .busy_o(busy_o), .v_o(v_o), .ready_i(ready_i), .data_o(data_o),
        .idx_o(idx_o), .last_o(last_o), .done_o(done_o)
    );

    bp_cfg_field_streamer #(.field_count_p(1), .field_width_p(FW)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start1), .cfg_i(cfg1),
        .busy_o(busy1), .v_o(v1), .ready_i(ready1), .data_o(data1),
        .idx_o(idx1), .last_o(last1), .done_o(done1)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] idx;
        logic [7:0] data;
    } word_t;

    word_t q0[$];
    word_t q1[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done1_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        word_t w;
        if (v_o && ready_i) begin
            if (q0.size() == 0) check("extra_word", 32'(data_o), 32'hDEAD);
            else begin
                w = q0.pop_front();
                check("word", 32'({last_o, 8'(idx_o), data_o}), 32'(w));
            end
        end
        if (v1 && ready1) begin
            if (q1.size() == 0) check("extra_word1", 32'(data1), 32'hDEAD);
            else begin
                w = q1.pop_front();
                check("word1", 32'({last1, 8'(idx1), data1}), 32'(w));
            end
        end
        if (done_o) done_seen++;
        if (done1) done1_seen++;
    end

    function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Hand-computed checksums are passed in rather than derived.
    task automatic push_stream(input logic [31:0] cfg, input logic [7:0] csum);
        for (int k = 0; k < FC; k++) q0.push_back({1'b0, 8'(k), cfg[k*8 +: 8]});
        q0.push_back({1'b1, 8'(FC), csum});
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done_o && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done_o) check("done_timeout", 32'(cycles), 32'd0);
    endtask

    // mode 0: plain, 1: 3-cycle stall on field 2, 2: start/cfg poked while busy
    task automatic run(input logic [31:0] cfg, input logic [7:0] csum, input int mode, input string tag);
        int cycles = 0;
        int stall = 0;
        int d0 = done_seen;
        push_stream(cfg, csum);
        cfg_i = cfg; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, "_lat_v"}, 32'(v_o), 32'd1);
        check({tag, "_lat_data"}, 32'({idx_o, data_o}), 32'({3'd0, cfg[7:0]}));
        while (cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
            if (done_o) break;
            if (!ready_i) check({tag, "_hold"}, 32'({v_o, last_o, idx_o, data_o}), 32'({1'b1, 1'b0, 3'd2, 8'h03}));
            if (mode == 1 && v_o && idx_o == 3'd2 && stall < 3) begin
                ready_i = 1'b0; stall++;
            end else ready_i = 1'b1;
            if (mode == 2) begin
                if (cycles == 2) begin start_i = 1'b1; cfg_i = {4{8'hAA}}; end
                else start_i = 1'b0;
            end
        end
        check({tag, "_done_cycle"}, 32'(cycles), (mode == 1) ? 32'd8 : 32'd5);
        check({tag, "_idle_at_done"}, 32'({busy_o, v_o}), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_queue_empty"}, 32'(q0.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;
        logic [31:0] basic;
        basic = pack4(8'h01, 8'h02, 8'h03, 8'h04);
        reset_i = 1'b1; start_i = 1'b0; ready_i = 1'b1; cfg_i = '0;
        start1 = 1'b0; ready1 = 1'b1; cfg1 = '0;
        #1;
        check("rst_outputs", 32'({busy_o, v_o, last_o, done_o, idx_o, data_o}), 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(posedge clk); #1;

        run(basic, 8'hF6, 0, "basic");
        run(32'hFFFF_FFFF, 8'h04, 0, "wrap");
        run(basic, 8'hF6, 1, "stall");
        run(basic, 8'hF6, 2, "busy_start");

        // Abort mid-stream: only fields 0 and 1 transfer.
        q0.push_back({1'b0, 8'd0, 8'h01});
        q0.push_back({1'b0, 8'd1, 8'h02});
        d0 = done_seen;
        cfg_i = basic; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_idx", 32'(idx_o), 32'd2);
        #2 reset_i = 1'b1;
        #1;
        check("async_reset_drop", 32'({busy_o, v_o, done_o}), 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        check("reset_queue", 32'(q0.size()), 32'd0);
        @(posedge clk); #1;
        check("reset_no_done", 32'(done_seen - d0), 32'd0);
        run(basic, 8'hF6, 0, "after_reset");

        // Back-to-back with start_i held; cfg change after capture feeds stream two.
        push_stream(basic, 8'hF6);
        push_stream(pack4(8'h10, 8'h20, 8'h30, 8'h40), 8'h60);
        d0 = done_seen;
        cfg_i = basic; start_i = 1'b1;
        @(posedge clk); #1;
        cfg_i = pack4(8'h10, 8'h20, 8'h30, 8'h40);
        wait_done(cyc);
        check("b2b_first_cycles", 32'(cyc), 32'd5);
        check("b2b_gap_idle", 32'(v_o), 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("b2b_second_start", 32'({v_o, idx_o, data_o}), 32'({1'b1, 3'd0, 8'h10}));
        wait_done(cyc);
        check("b2b_second_cycles", 32'(cyc), 32'd5);
        @(posedge clk); #1;
        check("b2b_no_third", 32'(v_o), 32'd0);
        check("b2b_done_count", 32'(done_seen - d0), 32'd2);
        check("b2b_queue", 32'(q0.size()), 32'd0);

        // Single-field instance.
        q1.push_back({1'b0, 8'd0, 8'h10});
        q1.push_back({1'b1, 8'd1, 8'hF0});
        cfg1 = 8'h10; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("single_cycles", 32'(cyc), 32'd2);
        check("single_queue", 32'(q1.size()), 32'd0);
        @(posedge clk); #1;
        check("single_done_count", 32'(done1_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
